// File: rtl/regfile_sb_pkg.sv
// Shared widths for the register file slice and its scoreboard.
// FULLW is the default datapath width, REG_ADDR_W the default address width.
package regfile_sb_pkg;

    localparam int FULLW      = 32;
    localparam int REG_ADDR_W = 4;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard for load-use hazard detection.
// Claims take priority over port-B clears; waw_err is sticky until reset.
module regfile_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     claim_en,
    input  logic [ADDR_W-1:0]        claim_addr,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    output logic [(1<<ADDR_W)-1:0]   busy_vec,
    output logic [(1<<ADDR_W)-1:0]   busy_next,
    output logic                     waw_err
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             waw_q;
    logic             waw_d;

    // A write from port B in the same cycle retires the load, so it is not a WAW hazard.
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < DEPTH; r++) begin
            if (claim_en && claim_addr == ADDR_W'(r)) begin
                busy_d[r] = 1'b1;
            end else if (wb_en && wb_addr == ADDR_W'(r)) begin
                busy_d[r] = 1'b0;
            end
        end
        waw_d = waw_q | (wa_en & busy_q[wa_addr] & ~(wb_en && wb_addr == wa_addr));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            waw_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            waw_q  <= waw_d;
        end
    end

    assign busy_vec  = busy_q;
    assign busy_next = busy_d;
    assign waw_err   = waw_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with registered reads, two write ports,
// optional write-to-read bypass and a load-use busy scoreboard.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W = FULLW,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int NUM_RD = 3,
    parameter int BYPASS = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wa_en,
    input  logic [ADDR_W-1:0]          wa_addr,
    input  logic [DATA_W-1:0]          wa_data,
    input  logic                       wb_en,
    input  logic [ADDR_W-1:0]          wb_addr,
    input  logic [DATA_W-1:0]          wb_data,
    input  logic                       claim_en,
    input  logic [ADDR_W-1:0]          claim_addr,
    output logic [(1<<ADDR_W)-1:0]     busy_vec,
    output logic                       waw_err
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0]        mem_q [DEPTH];
    logic [NUM_RD*DATA_W-1:0] rdData_d;
    logic [NUM_RD*DATA_W-1:0] rdData_q;
    logic [NUM_RD-1:0]        rdBusy_d;
    logic [NUM_RD-1:0]        rdBusy_q;
    logic [DEPTH-1:0]         busyNext;
    logic [ADDR_W-1:0]        rdSel;
    logic [DATA_W-1:0]        rdVal;

    regfile_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .wa_en      (wa_en),
        .wa_addr    (wa_addr),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .busy_vec   (busy_vec),
        .busy_next  (busyNext),
        .waw_err    (waw_err)
    );

    // Port A is written last so it wins a same-address collision with the older load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            if (wb_en) begin
                mem_q[wb_addr] <= wb_data;
            end
            if (wa_en) begin
                mem_q[wa_addr] <= wa_data;
            end
        end
    end

    always_comb begin
        rdData_d = '0;
        rdBusy_d = '0;
        rdSel    = '0;
        rdVal    = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rdSel = rd_addr[i*ADDR_W +: ADDR_W];
            rdVal = mem_q[rdSel];
            if (BYPASS != 0) begin
                if (wb_en && wb_addr == rdSel) begin
                    rdVal = wb_data;
                end
                if (wa_en && wa_addr == rdSel) begin
                    rdVal = wa_data;
                end
            end
            rdData_d[i*DATA_W +: DATA_W] = rdVal;
            rdBusy_d[i]                  = busyNext[rdSel];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdData_q <= '0;
            rdBusy_q <= '0;
        end else begin
            rdData_q <= rdData_d;
            rdBusy_q <= rdBusy_d;
        end
    end

    assign rd_data = rdData_q;
    assign rd_busy = rdBusy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed and model-checked bench for regfile_sb: default build with bypass,
// plus a 4-port, 32-entry build without bypass.
module tb_regfile_sb;

    logic        clk;
    logic        rst_n;

    logic [11:0] rd_addr;
    logic [95:0] rd_data;
    logic [2:0]  rd_busy;
    logic        wa_en, wb_en, claim_en;
    logic [3:0]  wa_addr, wb_addr, claim_addr;
    logic [31:0] wa_data, wb_data;
    logic [15:0] busy_vec;
    logic        waw_err;

    logic [19:0]  nbRdAddr;
    logic [127:0] nbRdData;
    logic [3:0]   nbRdBusy;
    logic         nbWaEn, nbWbEn, nbClaimEn;
    logic [4:0]   nbWaAddr, nbWbAddr, nbClaimAddr;
    logic [31:0]  nbWaData, nbWbData;
    logic [31:0]  nbBusyVec;
    logic         nbWawErr;

    int vecCount  = 0;
    int missCount = 0;

    regfile_sb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wa_en      (wa_en),
        .wa_addr    (wa_addr),
        .wa_data    (wa_data),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .busy_vec   (busy_vec),
        .waw_err    (waw_err)
    );

    regfile_sb #(
        .DATA_W (32),
        .ADDR_W (5),
        .NUM_RD (4),
        .BYPASS (0)
    ) dut_nb (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr    (nbRdAddr),
        .rd_data    (nbRdData),
        .rd_busy    (nbRdBusy),
        .wa_en      (nbWaEn),
        .wa_addr    (nbWaAddr),
        .wa_data    (nbWaData),
        .wb_en      (nbWbEn),
        .wb_addr    (nbWbAddr),
        .wb_data    (nbWbData),
        .claim_en   (nbClaimEn),
        .claim_addr (nbClaimAddr),
        .busy_vec   (nbBusyVec),
        .waw_err    (nbWawErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        wa_en = 0; wa_addr = 0; wa_data = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0;
        claim_en = 0; claim_addr = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idleInputs();
        rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        vecCount++;
        if (rd_data !== 96'h0 || busy_vec !== 16'h0 || waw_err !== 1'b0 || rd_busy !== 3'b0) begin
            missCount++;
            $display("[TB] FAIL reset_initial got data=%h busy=%h waw=%b want all zero", rd_data, busy_vec, waw_err);
        end
        rst_n = 1;
        wa_en = 1; wa_addr = 3; wa_data = 32'hCAFE;
        claim_en = 1; claim_addr = 1;
        step();
        idleInputs();
        rd_addr = {3{4'd3}};
        step();
        vecCount++;
        if (rd_data[31:0] !== 32'hCAFE || busy_vec !== 16'h0002) begin
            missCount++;
            $display("[TB] FAIL pre_reset got data=%h busy=%h want 0000cafe 0002", rd_data[31:0], busy_vec);
        end
        #2;
        rst_n = 0;
        #1;
        vecCount++;
        if (rd_data !== 96'h0 || busy_vec !== 16'h0 || waw_err !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL async_reset got data=%h busy=%h waw=%b want all zero", rd_data, busy_vec, waw_err);
        end
        step();
        rst_n = 1;
        step();
        vecCount++;
        if (rd_data !== 96'h0) begin
            missCount++;
            $display("[TB] FAIL reset_cleared_reg got %h want 0", rd_data);
        end
    endtask

    task automatic test_read();
        rd_addr = '0;
        wa_en = 1; wa_addr = 3; wa_data = 32'hDEADBEEF;
        step();
        idleInputs();
        rd_addr = {3{4'd3}};
        step();
        vecCount++;
        if (rd_data !== {3{32'hDEADBEEF}}) begin
            missCount++;
            $display("[TB] FAIL read_all_ports got %h want %h", rd_data, {3{32'hDEADBEEF}});
        end
    endtask

    task automatic test_bypass();
        rd_addr = {4'd6, 4'd6, 4'd5};
        wa_en = 1; wa_addr = 5; wa_data = 32'h11;
        wb_en = 1; wb_addr = 6; wb_data = 32'h66;
        step();
        idleInputs();
        vecCount++;
        if (rd_data !== {32'h66, 32'h66, 32'h11}) begin
            missCount++;
            $display("[TB] FAIL bypass_ab got %h want %h", rd_data, {32'h66, 32'h66, 32'h11});
        end
        rd_addr = {3{4'd8}};
        wa_en = 1; wa_addr = 8; wa_data = 32'hA;
        wb_en = 1; wb_addr = 8; wb_data = 32'hB;
        step();
        idleInputs();
        vecCount++;
        if (rd_data !== {3{32'hA}}) begin
            missCount++;
            $display("[TB] FAIL bypass_a_over_b got %h want %h", rd_data, {3{32'hA}});
        end
    endtask

    task automatic test_bypass_off();
        nbRdAddr = {4{5'd5}};
        nbWaEn = 1; nbWaAddr = 5; nbWaData = 32'h11;
        step();
        nbWaEn = 0;
        vecCount++;
        if (nbRdData !== 128'h0) begin
            missCount++;
            $display("[TB] FAIL nobypass_old got %h want 0", nbRdData);
        end
        step();
        vecCount++;
        if (nbRdData !== {4{32'h11}}) begin
            missCount++;
            $display("[TB] FAIL nobypass_new got %h want %h", nbRdData, {4{32'h11}});
        end
    endtask

    task automatic test_collision();
        rd_addr = '0;
        claim_en = 1; claim_addr = 7;
        step();
        idleInputs();
        vecCount++;
        if (busy_vec[7] !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL collision_claim got %b want 1", busy_vec[7]);
        end
        wa_en = 1; wa_addr = 7; wa_data = 32'hAAAA;
        wb_en = 1; wb_addr = 7; wb_data = 32'h5555;
        step();
        idleInputs();
        rd_addr = {3{4'd7}};
        vecCount++;
        if (busy_vec[7] !== 1'b0 || waw_err !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL collision_busy got busy=%b waw=%b want 0 0", busy_vec[7], waw_err);
        end
        step();
        vecCount++;
        if (rd_data !== {3{32'hAAAA}}) begin
            missCount++;
            $display("[TB] FAIL collision_data got %h want %h", rd_data, {3{32'hAAAA}});
        end
    endtask

    task automatic test_scoreboard();
        rd_addr = {3{4'd2}};
        claim_en = 1; claim_addr = 2;
        step();
        idleInputs();
        vecCount++;
        if (busy_vec !== 16'h0004 || rd_busy !== 3'b111) begin
            missCount++;
            $display("[TB] FAIL sb_claim got busy=%h rd_busy=%b want 0004 111", busy_vec, rd_busy);
        end
        wb_en = 1; wb_addr = 2; wb_data = 32'h42;
        step();
        idleInputs();
        vecCount++;
        if (busy_vec !== 16'h0 || rd_busy !== 3'b000 || rd_data[31:0] !== 32'h42) begin
            missCount++;
            $display("[TB] FAIL sb_clear got busy=%h rd_busy=%b data=%h want 0 000 42", busy_vec, rd_busy, rd_data[31:0]);
        end
        step();
        vecCount++;
        if (rd_data !== {3{32'h42}}) begin
            missCount++;
            $display("[TB] FAIL sb_stored got %h want %h", rd_data, {3{32'h42}});
        end
        claim_en = 1; claim_addr = 2;
        wb_en = 1; wb_addr = 2; wb_data = 32'h43;
        step();
        idleInputs();
        vecCount++;
        if (busy_vec !== 16'h0004 || rd_busy !== 3'b111) begin
            missCount++;
            $display("[TB] FAIL sb_claim_priority got busy=%h rd_busy=%b want 0004 111", busy_vec, rd_busy);
        end
        wb_en = 1; wb_addr = 2; wb_data = 32'h44;
        step();
        idleInputs();
    endtask

    task automatic test_waw();
        rd_addr = '0;
        vecCount++;
        if (waw_err !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL waw_initial got %b want 0", waw_err);
        end
        claim_en = 1; claim_addr = 9;
        step();
        idleInputs();
        wa_en = 1; wa_addr = 9; wa_data = 32'h1;
        wb_en = 1; wb_addr = 9; wb_data = 32'h2;
        step();
        idleInputs();
        vecCount++;
        if (waw_err !== 1'b0 || busy_vec[9] !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL waw_with_wb got waw=%b busy9=%b want 0 0", waw_err, busy_vec[9]);
        end
        claim_en = 1; claim_addr = 9;
        step();
        idleInputs();
        wa_en = 1; wa_addr = 9; wa_data = 32'h1;
        step();
        idleInputs();
        vecCount++;
        if (waw_err !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL waw_set got %b want 1", waw_err);
        end
        wa_en = 1; wa_addr = 4; wa_data = 32'h4;
        wb_en = 1; wb_addr = 9; wb_data = 32'h9;
        claim_en = 1; claim_addr = 6;
        step();
        idleInputs();
        repeat (2) step();
        vecCount++;
        if (waw_err !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL waw_sticky got %b want 1", waw_err);
        end
    endtask

    task automatic test_random_nb();
        logic [31:0]  memM [32];
        logic [31:0]  busyM;
        logic [31:0]  busyN;
        logic         wawM;
        logic [127:0] expData;
        logic [3:0]   expBusy;
        logic [4:0]   a;
        rst_n = 0;
        nbWaEn = 0; nbWbEn = 0; nbClaimEn = 0;
        step();
        rst_n = 1;
        for (int r = 0; r < 32; r++) memM[r] = '0;
        busyM = '0;
        wawM  = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            nbWaEn      = ($urandom_range(0, 1) == 1);
            nbWaAddr    = 5'($urandom_range(0, 31));
            nbWaData    = $urandom;
            nbWbEn      = ($urandom_range(0, 2) == 0);
            nbWbAddr    = 5'($urandom_range(0, 31));
            nbWbData    = $urandom;
            nbClaimEn   = ($urandom_range(0, 3) == 0);
            nbClaimAddr = 5'($urandom_range(0, 31));
            for (int i = 0; i < 4; i++) nbRdAddr[i*5 +: 5] = 5'($urandom_range(0, 31));
            busyN = busyM;
            if (nbWbEn) busyN[nbWbAddr] = 1'b0;
            if (nbClaimEn) busyN[nbClaimAddr] = 1'b1;
            for (int i = 0; i < 4; i++) begin
                a = nbRdAddr[i*5 +: 5];
                expData[i*32 +: 32] = memM[a];
                expBusy[i] = busyN[a];
            end
            if (nbWaEn && busyM[nbWaAddr] && !(nbWbEn && nbWbAddr == nbWaAddr)) wawM = 1'b1;
            if (nbWbEn) memM[nbWbAddr] = nbWbData;
            if (nbWaEn) memM[nbWaAddr] = nbWaData;
            busyM = busyN;
            step();
            vecCount++;
            if (nbRdData !== expData || nbRdBusy !== expBusy || nbBusyVec !== busyM || nbWawErr !== wawM) begin
                missCount++;
                $display("[TB] FAIL random_cycle_%0d got data=%h rb=%b busy=%h waw=%b want data=%h rb=%b busy=%h waw=%b",
                         c, nbRdData, nbRdBusy, nbBusyVec, nbWawErr, expData, expBusy, busyM, wawM);
            end
        end
        nbWaEn = 0; nbWbEn = 0; nbClaimEn = 0;
    endtask

    initial begin
        nbRdAddr = '0;
        nbWaEn = 0; nbWaAddr = 0; nbWaData = 0;
        nbWbEn = 0; nbWbAddr = 0; nbWbData = 0;
        nbClaimEn = 0; nbClaimAddr = 0;
        test_reset();
        test_read();
        test_bypass();
        test_bypass_off();
        test_collision();
        test_scoreboard();
        test_waw();
        test_random_nb();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised multi-port register file for the CPU datapath, with a configurable number of registered read ports and two write ports. Port A is the ALU writeback; port B is the load/memory writeback. A per-register busy scoreboard lets decode detect load-use hazards. Optional write-to-read bypass means a read issued in the same cycle as a write returns the new value.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 4, register address width; depth = 1 << ADDR_W
NUM_RD, 3, number of read ports (>= 1)
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return pre-write contents

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
rd_addr  input  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  registered read data, port i at [i*DATA_W +: DATA_W]
rd_busy  output  NUM_RD  registered busy flag of the addressed register, per port
wa_en  input  1  write enable, port A (ALU)
wa_addr  input  ADDR_W  write address, port A
wa_data  input  DATA_W  write data, port A
wb_en  input  1  write enable, port B (load); also clears busy for wb_addr
wb_addr  input  ADDR_W  write address, port B
wb_data  input  DATA_W  write data, port B
claim_en  input  1  mark claim_addr busy (load issued)
claim_addr  input  ADDR_W  register being claimed
busy_vec  output  1<<ADDR_W  current scoreboard, bit r = register r busy
waw_err  output  1  sticky: port A wrote a busy register that was not cleared that cycle

Behaviour:
- Reset (rst_n low, asynchronous): all registers = 0, busy_vec = 0, rd_data = 0, rd_busy = 0, waw_err = 0. Reset applied mid-operation discards all pending claims; state holds at zero until the first rising edge after rst_n deasserts.
- Reads: 1-cycle latency.
  - rd_data[i] at edge n+1 = value of register rd_addr[i] sampled at edge n.
  - Reads occur every cycle; there is no read enable.
- Writes: registers update on the rising edge when enabled.
- Same-address A/B collision: if wa_en and wb_en target the same address in the same cycle, port A data is stored (A is the younger instruction). Busy for that address is still cleared.
- Bypass:
  - BYPASS=1: a read whose address matches an enabled write in the same cycle returns the write data, port A over port B.
  - BYPASS=0: the read returns the old contents.
- Scoreboard next-state per register r:
  - claim_en && claim_addr==r -> 1; claim has priority over clear in the same cycle.
  - else wb_en && wb_addr==r -> 0.
  - else hold.
  - Port A writes do not change busy.
- rd_busy[i] = busy next-state of rd_addr[i], registered alongside rd_data. It therefore reflects claims and clears made in the same cycle as the read.
- waw_err: set when wa_en, busy[wa_addr]==1, and !(wb_en && wb_addr==wa_addr). Cleared only by reset.
- All addresses are in range by construction (depth = 2^ADDR_W); no wrap or out-of-range handling is needed.
- Multiple read ports may address the same register; each returns identical data.

Decomposition:
- Shared defines: FULLW (= default DATA_W) and REG_ADDR_W (= 4). No typedefs needed.
- Natural sub-module: regfile_scoreboard. It holds busy_vec plus the claim/clear priority and waw_err logic, and exposes a combinational busy-next lookup for the read ports.
- Storage and the read/bypass mux stay in regfile_sb.

Test Plan:
- Reset and read: assert rst_n=0 mid-cycle -> rd_data, busy_vec, and waw_err immediately 0. Release, write A r3=0xDEADBEEF; next cycle read r3 on all ports -> 0xDEADBEEF on all ports after 1 cycle.
- Bypass: BYPASS=1, same cycle wa r5=0x11 and read r5 -> rd_data=0x11. Repeat with BYPASS=0 -> old value 0x0.
- Collision: wa r7=0xAAAA and wb r7=0x5555 together -> r7 reads 0xAAAA; busy[7] cleared if it was set.
- Scoreboard: claim r2 -> busy_vec[2]=1 and rd_busy=1 when reading r2. wb r2=0x42 -> busy_vec[2]=0 and r2=0x42. Claim and wb to r2 in the same cycle -> busy stays 1.
- WAW error: claim r9, then wa r9=0x1 with no wb -> waw_err=1 and stays 1 through later traffic. A repeat with a wb to r9 in the same cycle does not set waw_err.
- NUM_RD=4, ADDR_W=5 build: random writes and reads over 32 registers checked against a reference model for 10k cycles.
